fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch sequencer that sits at the consumer end of the PC path.
- Owns the fetch PC, issues requests to instruction memory over a req/ack handshake, and delivers instruction + PC to the IF/ID stage.
- Applies stall back-pressure, buffers one in-flight return in a skid entry, and handles branch/jump redirects, including stale-request draining.

Parameters:
- N_BITS, 32, address/PC width.
- INSTR_BITS, 32, instruction width.
- RESET_PC, 32'h0040_0000, fetch PC after reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_i  input  1  IF/ID not accepting this cycle.
- redirect_i  input  1  branch/jump taken; load new fetch PC.
- redirect_pc_i  input  N_BITS  redirect target.
- imem_req_o  output  1  memory request.
- imem_addr_o  output  N_BITS  request address.
- imem_ack_i  input  1  request completed; rdata valid this cycle.
- imem_rdata_i  input  INSTR_BITS  fetched instruction.
- instr_valid_o  output  1  instr_o/pc_o hold a valid instruction.
- instr_o  output  INSTR_BITS  instruction to IF/ID.
- pc_o  output  N_BITS  address of instr_o.
- pc_plus4_o  output  N_BITS  pc_o + 4, combinational, wraps mod 2^N_BITS.

Behaviour:
- Reset (reset=1 at edge):
  - pc_q=RESET_PC; state=FETCH; req_held=0.
  - instr_valid_o=0, instr_o=0, pc_o=0; skid_valid=0.
  - imem_req_o=0 in the cycle after reset.
  - Reset overrides all other inputs, including in mid-request; any in-flight ack is ignored.
- Output accept: out_fire = instr_valid_o & ~stall_i.
- Handshake rule: once imem_req_o is high without ack, it and imem_addr_o stay stable until ack. A transfer completes on an edge with imem_req_o=1 and imem_ack_i=1. Zero-wait memory (ack in the request cycle) gives 1 instruction/cycle.
- FETCH state:
  - New request starts when ~req_held & ~skid_valid & (~instr_valid_o | out_fire) & ~redirect_i.
  - imem_req_o = start | req_held.
  - imem_addr_o = req_held ? req_addr_q : pc_q.
  - Start without ack: req_held<=1, req_addr_q<=pc_q.
  - On ack: pc_q<=pc_q+4 (wraps 0xFFFF_FFFC->0), req_held<=0, and the data/address is routed as follows:
    - out register if (~instr_valid_o | out_fire) and skid empty;
    - otherwise skid entry.
  - Output drain: when out_fire and skid_valid, the skid entry moves to out; skid_valid<=0.
  - When out_fire and nothing refills out, instr_valid_o<=0.
- Redirect (redirect_i=1, state FETCH or DRAIN):
  - pc_q <= {redirect_pc_i[N_BITS-1:2],2'b00}.
  - instr_valid_o<=0, skid_valid<=0 (flush).
  - No new request starts this cycle.
  - Request pending and no ack this cycle: state<=DRAIN; req_held stays 1; address unchanged.
  - Ack this cycle: data discarded; no pc increment; state<=FETCH.
  - Redirect has priority over stall, increment, and ack capture.
- DRAIN state:
  - imem_req_o=1, imem_addr_o=req_addr_q.
  - On ack: data discarded, req_held<=0, state<=FETCH.
  - Further redirects in DRAIN only update pc_q (last one wins).
  - Outputs stay invalid throughout.
- Stall holds instr_valid_o/instr_o/pc_o unchanged; the held request continues to completion and lands in skid.
- Ordering: instructions leave in PC order with no duplicates or losses, absent redirect.

Test Plan:
- Reset, zero-wait memory (ack=req, rdata=addr), stall_i=0 -> addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; instr_valid_o high from the 2nd cycle; pc_plus4_o=pc_o+4.
- 3-cycle ack latency -> imem_addr_o stable 0x00400000 for 3 cycles; then valid with pc_o=0x00400000; next req at 0x00400004.
- stall_i=1 while a request is held, ack arrives -> out holds 0x00400000, skid takes 0x00400004, no new req. Stall release -> 0x00400000 then 0x00400004 delivered, then fetch of 0x00400008.
- Redirect to 0x00400103 during a pending 2-cycle request at 0x00400010 -> DRAIN; stale ack discarded; outputs invalid; next req at 0x00400100.
- Redirect coincident with ack and with stall_i=1 -> ack data dropped; out and skid flushed; next addr=redirect target.
- pc_q=0xFFFFFFFC fetch -> next addr 0x00000000, pc_plus4_o=0. reset=1 mid-request -> all outputs cleared next edge; req restarts at 0x00400000.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit                                                      |
// | Brief    : Fetch PC sequencer with req/ack imem port, skid entry, redirect.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter int                N_BITS     = 32,
  parameter int                INSTR_BITS = 32,
  parameter logic [N_BITS-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [N_BITS-1:0]     redirect_pc_i,
  output logic                  imem_req_o,
  output logic [N_BITS-1:0]     imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [INSTR_BITS-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [INSTR_BITS-1:0] instr_o,
  output logic [N_BITS-1:0]     pc_o,
  output logic [N_BITS-1:0]     pc_plus4_o
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam logic [N_BITS-1:0] c_PC_STEP    = N_BITS'(4);
  localparam logic [N_BITS-1:0] c_ALIGN_MASK = ~N_BITS'(3);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [N_BITS-1:0]       r_pc_q;
  logic [N_BITS-1:0]       r_req_addr_q;
  logic                    r_req_held;
  logic                    r_rst_q;
  logic                    r_instr_valid;
  logic [INSTR_BITS-1:0]   r_instr;
  logic [N_BITS-1:0]       r_pc_out;
  logic                    r_skid_valid;
  logic [INSTR_BITS-1:0]   r_skid_instr;
  logic [N_BITS-1:0]       r_skid_pc;

  logic                    w_out_fire;
  logic                    w_out_free;
  logic                    w_start;
  logic                    w_xfer;
  logic                    w_to_out;
  logic [N_BITS-1:0]       w_redirect_pc;

  assign w_out_fire    = r_instr_valid & ~stall_i;
  assign w_out_free    = ~r_instr_valid | w_out_fire;
  // r_rst_q keeps the request line quiet for the first cycle after reset
  assign w_start       = (r_state == S_FETCH) & ~r_rst_q & ~r_req_held &
                         ~r_skid_valid & w_out_free & ~redirect_i;
  assign imem_req_o    = w_start | r_req_held;
  assign imem_addr_o   = r_req_held ? r_req_addr_q : r_pc_q;
  assign w_xfer        = imem_req_o & imem_ack_i;
  assign w_to_out      = w_out_free & ~r_skid_valid;
  assign w_redirect_pc = redirect_pc_i & c_ALIGN_MASK;

  assign instr_valid_o = r_instr_valid;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_out;
  assign pc_plus4_o    = r_pc_out + c_PC_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (redirect_i & r_req_held & ~imem_ack_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_ack_i) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_q        <= RESET_PC;
      r_req_addr_q  <= '0;
      r_req_held    <= 1'b0;
      r_rst_q       <= 1'b1;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_pc_out      <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= '0;
      r_skid_pc     <= '0;
    end else begin
      r_rst_q <= 1'b0;
      if (redirect_i) begin
        // Flush everything; a pending request stays held and is drained later
        r_pc_q        <= w_redirect_pc;
        r_instr_valid <= 1'b0;
        r_skid_valid  <= 1'b0;
        if (w_xfer) begin
          r_req_held <= 1'b0;
        end
      end else if (r_state == S_DRAIN) begin
        if (w_xfer) begin
          r_req_held <= 1'b0;
        end
      end else begin
        if (w_xfer) begin
          r_pc_q     <= r_pc_q + c_PC_STEP;
          r_req_held <= 1'b0;
        end else if (w_start) begin
          r_req_held   <= 1'b1;
          r_req_addr_q <= r_pc_q;
        end

        if (w_out_fire & r_skid_valid) begin
          r_instr  <= r_skid_instr;
          r_pc_out <= r_skid_pc;
        end else if (w_xfer & w_to_out) begin
          r_instr       <= imem_rdata_i;
          r_pc_out      <= imem_addr_o;
          r_instr_valid <= 1'b1;
        end else if (w_out_fire) begin
          r_instr_valid <= 1'b0;
        end

        if (w_xfer & ~w_to_out) begin
          r_skid_instr <= imem_rdata_i;
          r_skid_pc    <= imem_addr_o;
          r_skid_valid <= 1'b1;
        end else if (w_out_fire) begin
          r_skid_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a stream-level model (PC order, redirect targets, stale-return drops).
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int checks = 0;
  int errors = 0;

  // memory model state
  int lat      = 0;
  int wait_cnt = 0;
  bit rand_lat = 0;

  // values sampled mid-cycle
  logic        s_req, s_ack, s_valid;
  logic [31:0] s_addr, s_pc, s_instr, s_pp4;

  fetch_unit #(
    .N_BITS    (32),
    .INSTR_BITS(32),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // One clock cycle: memory answers at negedge, state advances at posedge.
  task automatic tick();
    @(negedge clk);
    if (imem_req_o && wait_cnt >= lat) begin
      imem_ack_i   = 1'b1;
      imem_rdata_i = mem_word(imem_addr_o);
    end else begin
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
    end
    #1;
    s_req = imem_req_o; s_addr = imem_addr_o; s_ack = imem_ack_i;
    s_valid = instr_valid_o; s_pc = pc_o; s_instr = instr_o; s_pp4 = pc_plus4_o;
    @(posedge clk);
    #1;
    if (reset) wait_cnt = 0;
    else if (s_req && s_ack) begin
      wait_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else if (s_req) wait_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    rand_lat = 0; lat = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h1234_5678;
    rand_lat = 0; lat = 0;
    tick(); tick();
    reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc_o); end
    checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %b expected 0", s_req); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (s_req !== 1'b1 || s_addr !== RST_PC + 4*k) begin errors++; $display("FAIL zw_req%0d: got req=%b addr=%h expected 1 %h", k, s_req, s_addr, RST_PC + 4*k); end
      checks++; if (instr_valid_o !== 1'b1 || pc_o !== RST_PC + 4*k || instr_o !== mem_word(RST_PC + 4*k)) begin errors++; $display("FAIL zw_out%0d: got v=%b pc=%h i=%h expected 1 %h %h", k, instr_valid_o, pc_o, instr_o, RST_PC + 4*k, mem_word(RST_PC + 4*k)); end
      checks++; if (pc_plus4_o !== RST_PC + 4*k + 4) begin errors++; $display("FAIL zw_pp4%0d: got %h expected %h", k, pc_plus4_o, RST_PC + 4*k + 4); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    lat = 2;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (s_req !== 1'b1 || s_addr !== RST_PC || s_ack !== (k == 2)) begin errors++; $display("FAIL lat_hold%0d: got req=%b addr=%h ack=%b expected 1 %h %b", k, s_req, s_addr, s_ack, RST_PC, (k == 2)); end
      checks++; if (instr_valid_o !== (k == 2)) begin errors++; $display("FAIL lat_valid%0d: got %b expected %b", k, instr_valid_o, (k == 2)); end
    end
    checks++; if (pc_o !== RST_PC) begin errors++; $display("FAIL lat_pc: got %h expected %h", pc_o, RST_PC); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== RST_PC + 4) begin errors++; $display("FAIL lat_next: got req=%b addr=%h expected 1 %h", s_req, s_addr, RST_PC + 4); end
  endtask

  task automatic test_stall();
    do_reset();
    stall_i = 1'b1; lat = 2;
    tick(); tick(); tick();
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== RST_PC) begin errors++; $display("FAIL stall_land: got v=%b pc=%h expected 1 %h", instr_valid_o, pc_o, RST_PC); end
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_noreq: got %b expected 0", s_req); end
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== RST_PC || instr_o !== mem_word(RST_PC)) begin errors++; $display("FAIL stall_hold: got v=%b pc=%h i=%h expected 1 %h %h", instr_valid_o, pc_o, instr_o, RST_PC, mem_word(RST_PC)); end
    stall_i = 1'b0;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== RST_PC + 4) begin errors++; $display("FAIL stall_release: got req=%b addr=%h expected 1 %h", s_req, s_addr, RST_PC + 4); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b expected 0", instr_valid_o); end
    tick(); tick();
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== RST_PC + 4) begin errors++; $display("FAIL stall_second: got v=%b pc=%h expected 1 %h", instr_valid_o, pc_o, RST_PC + 4); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    repeat (4) tick();
    lat = 2;
    tick();
    checks++; if (s_addr !== RST_PC + 32'h10 || s_ack !== 1'b0) begin errors++; $display("FAIL drain_req: got addr=%h ack=%b expected %h 0", s_addr, s_ack, RST_PC + 32'h10); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0103;
    tick();
    redirect_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL drain_flush: got %b expected 0", instr_valid_o); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== RST_PC + 32'h10 || s_ack !== 1'b1) begin errors++; $display("FAIL drain_stale: got req=%b addr=%h ack=%b expected 1 %h 1", s_req, s_addr, s_ack, RST_PC + 32'h10); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL drain_discard: got %b expected 0", instr_valid_o); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0040_0100) begin errors++; $display("FAIL drain_target: got req=%b addr=%h expected 1 00400100", s_req, s_addr); end
  endtask

  task automatic test_redirect_ack_stall();
    do_reset();
    tick();
    lat = 1;
    tick();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0040_0200;
    tick();
    redirect_i = 1'b0;
    checks++; if (s_ack !== 1'b1 || s_addr !== RST_PC + 4) begin errors++; $display("FAIL rack_ack: got ack=%b addr=%h expected 1 %h", s_ack, s_addr, RST_PC + 4); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rack_drop: got %b expected 0", instr_valid_o); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0040_0200) begin errors++; $display("FAIL rack_target: got req=%b addr=%h expected 1 00400200", s_req, s_addr); end
    tick();
    checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0040_0200) begin errors++; $display("FAIL rack_land: got v=%b pc=%h expected 1 00400200", instr_valid_o, pc_o); end
    stall_i = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL wrap_noreq: got %b expected 0", s_req); end
    tick();
    checks++; if (s_addr !== 32'hFFFF_FFFC || pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin errors++; $display("FAIL wrap_top: got addr=%h pc=%h pp4=%h expected fffffffc fffffffc 00000000", s_addr, pc_o, pc_plus4_o); end
    tick();
    checks++; if (s_addr !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL wrap_zero: got addr=%h pc=%h expected 00000000 00000000", s_addr, pc_o); end
    lat = 3;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h4 || s_ack !== 1'b0) begin errors++; $display("FAIL wrap_pend: got req=%b addr=%h ack=%b expected 1 00000004 0", s_req, s_addr, s_ack); end
    reset = 1'b1;
    tick();
    reset = 1'b0; lat = 0;
    #1;
    checks++; if (instr_valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL midreset_clear: got v=%b pc=%h i=%h req=%b expected 0 0 0 0", instr_valid_o, pc_o, instr_o, imem_req_o); end
    tick();
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== RST_PC) begin errors++; $display("FAIL midreset_restart: got req=%b addr=%h expected 1 %h", s_req, s_addr, RST_PC); end
  endtask

  // Stream-level model: deliveries and fetch addresses advance by 4 from the last
  // redirect target; a request outstanding at a redirect returns stale data.
  task automatic test_random();
    logic [31:0] exp_deliver, exp_fetch, prev_addr, tgt;
    bit          stale, prev_pending, prev_redirect;
    int          delivered;
    do_reset();
    rand_lat = 1; lat = $urandom_range(0, 3);
    exp_deliver = RST_PC; exp_fetch = RST_PC;
    stale = 0; prev_pending = 0; prev_redirect = 0; delivered = 0; prev_addr = '0;
    for (int c = 0; c < 4000; c++) begin
      stall_i    = ($urandom_range(0, 99) < 30);
      redirect_i = ($urandom_range(0, 99) < 4);
      redirect_pc_i = $urandom;
      if ($urandom_range(0, 7) == 0) redirect_pc_i = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      tick();
      if (prev_pending) begin
        checks++; if (s_req !== 1'b1 || s_addr !== prev_addr) begin errors++; $display("FAIL rnd_hold c=%0d: got req=%b addr=%h expected 1 %h", c, s_req, s_addr, prev_addr); end
      end
      checks++; if (s_pp4 !== s_pc + 32'd4) begin errors++; $display("FAIL rnd_pp4 c=%0d: got %h expected %h", c, s_pp4, s_pc + 32'd4); end
      if (prev_redirect || stale) begin
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush c=%0d: got valid=%b expected 0", c, s_valid); end
      end
      if (s_valid && !stall_i && !redirect_i) begin
        checks++; if (s_pc !== exp_deliver || s_instr !== mem_word(exp_deliver)) begin errors++; $display("FAIL rnd_deliver c=%0d: got pc=%h i=%h expected %h %h", c, s_pc, s_instr, exp_deliver, mem_word(exp_deliver)); end
        exp_deliver += 32'd4;
        delivered++;
      end
      if (s_req && s_ack) begin
        if (!redirect_i && !stale) begin
          checks++; if (s_addr !== exp_fetch) begin errors++; $display("FAIL rnd_fetch c=%0d: got addr=%h expected %h", c, s_addr, exp_fetch); end
          exp_fetch += 32'd4;
        end
        stale = 0;
      end
      if (redirect_i) begin
        tgt = redirect_pc_i & 32'hFFFF_FFFC;
        exp_fetch = tgt; exp_deliver = tgt;
        if (s_req && !s_ack) stale = 1;
      end
      prev_pending  = s_req && !s_ack;
      prev_addr     = s_addr;
      prev_redirect = redirect_i;
    end
    stall_i = 1'b0; redirect_i = 1'b0; rand_lat = 0;
    checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d deliveries expected at least 200", delivered); end
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_drain();
    test_redirect_ack_stall();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
